// File: rtl/fetch_mem_arbiter.sv
// fetch_mem_arbiter: shares one single-ported, synchronous-read instruction
// RAM (IMEM/BIOS) between the fetch requester and the data requester.
// Data wins conflicts unless fetch has been denied STARVE_LIMIT cycles in a
// row. Read data returns one cycle after the grant and is routed back to the
// requester that owns the in-flight read.
// Optional build macro: FETCH_ARB_PERF_EN enables the perf_conflicts counter;
// without it perf_conflicts is tied to zero.
module fetch_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,   // legal range 1..15
  parameter int unsigned BIOS_BIT     = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_stall,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        mem_req,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_we,
  input  logic [31:0] mem_wdata,
  output logic        mem_stall,
  output logic        mem_rvalid,
  output logic [31:0] mem_rdata,
  output logic        ram_en,
  output logic [29:0] ram_addr,
  output logic [3:0]  ram_we,
  output logic [31:0] ram_wdata,
  output logic        ram_bios_sel,
  input  logic [31:0] ram_rdata,
  output logic [31:0] perf_conflicts
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RD_IF  = 2'd1;
  localparam logic [1:0] ST_RD_MEM = 2'd2;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic [1:0]  state_q, state_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        gnt_if, gnt_mem;
  logic [31:0] gnt_addr;

  // Pick at most one requester per cycle; data wins unless fetch is starved.
  always_comb begin
    // NOTE: defaults first so every path assigns both grants -> no latch.
    gnt_if  = 1'b0;
    gnt_mem = 1'b0;
    if (if_req && mem_req) begin
      if (starve_cnt_q == STARVE_MAX) gnt_if  = 1'b1;
      else                            gnt_mem = 1'b1;
    end else if (if_req) begin
      gnt_if = 1'b1;
    end else if (mem_req) begin
      gnt_mem = 1'b1;
    end
  end

  assign if_stall  = if_req  && !gnt_if;
  assign mem_stall = mem_req && !gnt_mem;

  // RAM request is steered from whichever side holds the grant.
  assign gnt_addr     = gnt_mem ? mem_addr : if_addr;
  assign ram_en       = gnt_if | gnt_mem;
  assign ram_addr     = gnt_addr[31:2];
  assign ram_we       = gnt_mem ? mem_we : 4'b0000;
  assign ram_wdata    = mem_wdata;
  assign ram_bios_sel = gnt_addr[BIOS_BIT];

  // Byte-lane bits never reach the word-addressed RAM.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^gnt_addr[1:0];

  // Count consecutive denied fetch cycles, saturating at the limit.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!if_req || gnt_if)             starve_cnt_d = 4'd0;
    else if (starve_cnt_q != STARVE_MAX) starve_cnt_d = starve_cnt_q + 4'd1;
  end

  // Record who owns the read issued this cycle; writes and squashed fetches
  // leave nothing in flight.
  always_comb begin
    state_d = ST_IDLE;
    if (gnt_if && !if_flush)           state_d = ST_RD_IF;
    else if (gnt_mem && mem_we == 4'b0) state_d = ST_RD_MEM;
  end

  // Arbiter state registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments for all sequential state.
    if (rst) begin
      state_q      <= ST_IDLE;
      starve_cnt_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // A flush in the response cycle still squashes the fetch response.
  assign if_rvalid  = (state_q == ST_RD_IF) && !if_flush;
  assign mem_rvalid = (state_q == ST_RD_MEM);
  assign if_rdata   = ram_rdata;
  assign mem_rdata  = ram_rdata;

`ifdef FETCH_ARB_PERF_EN
  logic [31:0] perf_q, perf_d;

  // Cycles where both sides collide; wraps naturally at 2^32.
  always_comb perf_d = perf_q + {31'd0, if_req & mem_req};

  // Conflict counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) perf_q <= 32'd0;
    else     perf_q <= perf_d;
  end

  assign perf_conflicts = perf_q;
`else
  assign perf_conflicts = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// Self-checking bench for fetch_mem_arbiter: directed scenarios followed by
// randomized traffic, all judged by a transaction-level reference model
// (shadow memory, expected-response slot, denial counter).
module tb_fetch_mem_arbiter;

  localparam int LIMIT = 4;
  localparam int BIOS  = 30;
  localparam int W_NONE = 0;
  localparam int W_IF   = 1;
  localparam int W_MEM  = 2;

  logic        clk, rst;
  logic        if_req, if_flush, if_stall, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        mem_req, mem_stall, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_we;
  logic        ram_en, ram_bios_sel;
  logic [29:0] ram_addr;
  logic [3:0]  ram_we;
  logic [31:0] ram_wdata, ram_rdata;
  logic [31:0] perf_conflicts;

  fetch_mem_arbiter #(.STARVE_LIMIT(LIMIT), .BIOS_BIT(BIOS)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_stall(if_stall), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_stall(mem_stall), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata),
    .ram_en(ram_en), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_bios_sel(ram_bios_sel),
    .ram_rdata(ram_rdata), .perf_conflicts(perf_conflicts)
  );

  always #5 clk = ~clk;

  // Environment RAM: 16 words, byte-write, write-first, one-cycle read.
  logic [31:0] ram [16];
  logic [31:0] ram_word;
  always @(posedge clk) begin
    if (ram_en) begin
      ram_word = ram[ram_addr[3:0]];
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) ram_word[8*b +: 8] = ram_wdata[8*b +: 8];
      ram[ram_addr[3:0]] = ram_word;
      ram_rdata <= ram_word;
    end
  end

  // Reference model state.
  logic [31:0] shadow [16];
  int          m_pend;
  logic [31:0] m_pend_data;
  int          m_starve;
  logic [31:0] m_perf;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pend   = W_NONE;
    m_starve = 0;
    m_perf   = 32'd0;
  endtask

  function automatic logic [31:0] exp_perf();
`ifdef FETCH_ARB_PERF_EN
    return m_perf;
`else
    return 32'd0;
`endif
  endfunction

  // Drive one cycle of stimulus, check every output against the model, then
  // advance the model to what the coming clock edge should produce.
  task automatic step(input logic ir, input logic [31:0] ia, input logic fl,
                      input logic mr, input logic [31:0] ma, input logic [3:0] mw,
                      input logic [31:0] md, input logic rs);
    int          win;
    logic [31:0] ga, word;
    @(negedge clk);
    rst = rs; if_req = ir; if_addr = ia; if_flush = fl;
    mem_req = mr; mem_addr = ma; mem_we = mw; mem_wdata = md;
    #1;
    if (rs) model_reset();
    if (ir && mr)  win = (m_starve >= LIMIT) ? W_IF : W_MEM;
    else if (ir)   win = W_IF;
    else if (mr)   win = W_MEM;
    else           win = W_NONE;
    ga = (win == W_MEM) ? ma : ia;

    check("if_stall",  32'(if_stall),  32'(ir && win != W_IF));
    check("mem_stall", 32'(mem_stall), 32'(mr && win != W_MEM));
    check("ram_en",    32'(ram_en),    32'(win != W_NONE));
    check("ram_we",    32'(ram_we),    32'((win == W_MEM) ? mw : 4'b0));
    if (win != W_NONE) begin
      check("ram_addr", {2'b00, ram_addr}, {2'b00, ga[31:2]});
      check("ram_bios_sel", 32'(ram_bios_sel), 32'(ga[BIOS]));
    end
    if (win == W_MEM && mw != 4'b0) check("ram_wdata", ram_wdata, md);
    check("if_rvalid",  32'(if_rvalid),  32'(m_pend == W_IF && !fl));
    check("mem_rvalid", 32'(mem_rvalid), 32'(m_pend == W_MEM));
    if (m_pend == W_IF && !fl) check("if_rdata", if_rdata, m_pend_data);
    if (m_pend == W_MEM)       check("mem_rdata", mem_rdata, m_pend_data);
    check("perf_conflicts", perf_conflicts, exp_perf());

    word = shadow[ga[5:2]];
    if (win == W_MEM)
      for (int b = 0; b < 4; b++)
        if (mw[b]) word[8*b +: 8] = md[8*b +: 8];
    if (win != W_NONE) shadow[ga[5:2]] = word;

    if (!rs) begin
      if (win == W_IF && !fl)              m_pend = W_IF;
      else if (win == W_MEM && mw == 4'b0) m_pend = W_MEM;
      else                                 m_pend = W_NONE;
      m_pend_data = word;
      if (!ir || win == W_IF) m_starve = 0;
      else if (m_starve < LIMIT) m_starve++;
      if (ir && mr) m_perf = m_perf + 32'd1;
    end
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(0, 3) != 0) a = a & 32'h4000_003C;
    return a;
  endfunction

  initial begin
    clk = 1'b0; rst = 1'b1;
    if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    mem_req = 1'b0; mem_addr = '0; mem_we = '0; mem_wdata = '0;
    for (int i = 0; i < 16; i++) begin
      ram[i] = $urandom;
      shadow[i] = ram[i];
    end
    ram[4] = 32'hDEAD_BEEF; shadow[4] = 32'hDEAD_BEEF;
    ram[5] = 32'hAAAA_AAAA; shadow[5] = 32'hAAAA_AAAA;
    model_reset();

    // Reset state, and grant logic still live while reset is held.
    #2;
    check("rst_if_rvalid",  32'(if_rvalid),  32'd0);
    check("rst_mem_rvalid", 32'(mem_rvalid), 32'd0);
    check("rst_perf",       perf_conflicts,  32'd0);
    if_req = 1'b1; mem_req = 1'b1;
    #1;
    check("rst_comb_if_stall", 32'(if_stall), 32'd1);
    check("rst_comb_ram_en",   32'(ram_en),   32'd1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
    idle();

    // Fetch only from BIOS space.
    step(1'b1, 32'h4000_0010, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    check("fetch_ram_addr", {2'b00, ram_addr}, 32'h1000_0004);
    check("fetch_bios_sel", 32'(ram_bios_sel), 32'd1);
    idle();
    check("fetch_rvalid", 32'(if_rvalid), 32'd1);
    check("fetch_rdata",  if_rdata, 32'hDEAD_BEEF);

    // One-cycle conflict: data wins.
    step(1'b1, 32'h4000_0010, 1'b0, 1'b1, 32'h0000_0020, 4'h0, 32'h0, 1'b0);
    check("conflict_if_stall", 32'(if_stall), 32'd1);
    idle();
    check("conflict_mem_rvalid", 32'(mem_rvalid), 32'd1);
    check("conflict_if_rvalid",  32'(if_rvalid),  32'd0);

    // Sustained conflict: fetch forced through every LIMIT+1 cycles.
    for (int k = 0; k < 2 * (LIMIT + 1); k++) begin
      step(1'b1, rand_addr(), 1'b0, 1'b1, rand_addr(), 4'h0, 32'h0, 1'b0);
      check("starve_pattern", 32'(if_stall), 32'((k % (LIMIT + 1)) != LIMIT));
    end
    idle();

    // Flush in the grant cycle, then a clean fetch.
    step(1'b1, 32'h4000_0010, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    step(1'b1, 32'h4000_0010, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    check("flush_n_rvalid", 32'(if_rvalid), 32'd0);
    idle();
    check("flush_n1_fetch_resp", 32'(if_rvalid), 32'd1);
    // Flush in the response cycle.
    step(1'b1, 32'h4000_0010, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    check("flush_resp_rvalid", 32'(if_rvalid), 32'd0);
    idle();

    // Partial write followed by a fetch of the same word.
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0014, 4'b0011, 32'h1234_5678, 1'b0);
    step(1'b1, 32'h0000_0014, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    check("write_no_mem_rvalid", 32'(mem_rvalid), 32'd0);
    idle();
    check("wr_rd_rvalid", 32'(if_rvalid), 32'd1);
    check("wr_rd_rdata",  if_rdata, 32'hAAAA_5678);

    // Three conflicts, a fetch, then reset before the response is consumed.
    for (int k = 0; k < 3; k++)
      step(1'b1, rand_addr(), 1'b0, 1'b1, rand_addr(), 4'h0, 32'h0, 1'b0);
    step(1'b1, 32'h4000_0010, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    @(posedge clk);
    #2;
    check("midrd_pre_rvalid", 32'(if_rvalid), 32'd1);
    check("midrd_pre_perf",   perf_conflicts, exp_perf());
    rst = 1'b1;
    #1;
    model_reset();
    check("midrd_if_rvalid",  32'(if_rvalid),  32'd0);
    check("midrd_mem_rvalid", 32'(mem_rvalid), 32'd0);
    check("midrd_perf",       perf_conflicts,  32'd0);
    step(1'b1, 32'h4000_0010, 1'b0, 1'b1, 32'h20, 4'h0, 32'h0, 1'b1);
    idle();
    idle();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 99) < 60, rand_addr(), $urandom_range(0, 9) == 0,
           $urandom_range(0, 99) < 55, rand_addr(),
           ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom), $urandom,
           $urandom_range(0, 199) == 0);
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
